// File: rtl/mcs51_pkg.sv
// Shared MCS-51 definitions: timer CTRL bit positions, per-channel register
// offsets and the timer mode encoding.
package mcs51_pkg;

    typedef enum logic [1:0] {
        TMR_MODE_FREE    = 2'b00,
        TMR_MODE_RELOAD  = 2'b01,
        TMR_MODE_ONESHOT = 2'b10,
        TMR_MODE_RSVD    = 2'b11
    } tmr_mode_e;

    localparam int TMR_CTRL_RUN     = 0;
    localparam int TMR_CTRL_MODE_LO = 1;
    localparam int TMR_CTRL_MODE_HI = 2;
    localparam int TMR_CTRL_CT      = 3;
    localparam int TMR_CTRL_GATE    = 4;
    localparam int TMR_CTRL_IE      = 5;
    localparam int TMR_CTRL_CAPF    = 6;
    localparam int TMR_CTRL_OVF     = 7;

    localparam logic [2:0] TMR_OFF_CTRL  = 3'd0;
    localparam logic [2:0] TMR_OFF_CNT_L = 3'd1;
    localparam logic [2:0] TMR_OFF_CNT_H = 3'd2;
    localparam logic [2:0] TMR_OFF_RLD_L = 3'd3;
    localparam logic [2:0] TMR_OFF_RLD_H = 3'd4;
    localparam logic [2:0] TMR_OFF_CAP_L = 3'd5;
    localparam logic [2:0] TMR_OFF_CAP_H = 3'd6;
    localparam logic [2:0] TMR_OFF_RSVD  = 3'd7;

endpackage

// File: rtl/mcs51_tmr_chan.sv
// One timer/counter channel: CTRL, counter, reload, atomic read shadow and
// write hold. Capture logic exists only when MCS51_TMR_CAPTURE_EN is defined.
module mcs51_tmr_chan
    import mcs51_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pre_tick,
    input  logic       ext_tick,
    input  logic       gate_in,
    input  logic       cap_in,
    input  logic       wr_en,
    input  logic [2:0] wr_off,
    input  logic [7:0] wr_data,
    input  logic       rd_snap,
    input  logic [2:0] rd_off,
    input  logic       ack,
    output logic [7:0] rd_byte,
    output logic       run,
    output logic       irq
);

    localparam logic [7:0] HI_MASK = 8'((1 << (CNT_W - 8)) - 1);

    logic [7:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rld_q, rld_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       hold_q, hold_d;
    logic             tick_prev_q, tick_prev_d;
    logic [15:0]      cnt16, rld16;
    tmr_mode_e        mode;
    logic             fall, en, at_max, cnt_wr, ctrl_wr, ovf_evt, ovf_base, stop;

`ifdef MCS51_TMR_CAPTURE_EN
    logic [CNT_W-1:0] cap_q, cap_d;
    logic             cap_prev_q, cap_prev_d;
    logic             cap_evt;
    logic [15:0]      cap16;

    // Capture samples the counter before this cycle's increment.
    always_comb begin
        cap_evt    = cap_in & ~cap_prev_q;
        cap_prev_d = cap_in;
        cap_d      = cap_evt ? cnt_q : cap_q;
        cap16      = 16'(cap_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q      <= '0;
            cap_prev_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            cap_prev_q <= cap_prev_d;
        end
    end
`else
    logic unused_cap;
    assign unused_cap = cap_in;
`endif

    always_comb begin
        mode        = tmr_mode_e'(ctrl_q[TMR_CTRL_MODE_HI:TMR_CTRL_MODE_LO]);
        cnt16       = 16'(cnt_q);
        rld16       = 16'(rld_q);
        fall        = tick_prev_q & ~ext_tick;
        en          = ctrl_q[TMR_CTRL_RUN] & (~ctrl_q[TMR_CTRL_GATE] | gate_in) &
                      (ctrl_q[TMR_CTRL_CT] ? fall : pre_tick);
        cnt_wr      = wr_en && (wr_off == TMR_OFF_CNT_L);
        ctrl_wr     = wr_en && (wr_off == TMR_OFF_CTRL);
        at_max      = &cnt_q;
        ovf_evt     = en & at_max & ~cnt_wr;
        stop        = 1'b0;
        tick_prev_d = ext_tick;

        // A CPU counter write swallows a coincident tick entirely.
        cnt_d = cnt_q;
        if (cnt_wr) begin
            cnt_d = CNT_W'({hold_q, wr_data});
        end else if (en) begin
            if (!at_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                case (mode)
                    TMR_MODE_RELOAD:  cnt_d = rld_q;
                    TMR_MODE_ONESHOT: begin
                        cnt_d = rld_q;
                        stop  = 1'b1;
                    end
                    default:          cnt_d = '0;
                endcase
            end
        end

        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d[TMR_CTRL_IE:TMR_CTRL_RUN] = wr_data[5:0];
        end else if (stop) begin
            ctrl_d[TMR_CTRL_RUN] = 1'b0;
        end
        // A fresh overflow always survives a same-cycle ack or CTRL write.
        ovf_base = ctrl_wr ? wr_data[TMR_CTRL_OVF] : ctrl_q[TMR_CTRL_OVF];
        if (ack) begin
            ovf_base = 1'b0;
        end
        ctrl_d[TMR_CTRL_OVF] = ovf_base | ovf_evt;
`ifdef MCS51_TMR_CAPTURE_EN
        ctrl_d[TMR_CTRL_CAPF] = (ctrl_wr ? wr_data[TMR_CTRL_CAPF] : ctrl_q[TMR_CTRL_CAPF]) | cap_evt;
`else
        ctrl_d[TMR_CTRL_CAPF] = 1'b0;
`endif

        rld_d = rld_q;
        if (wr_en && (wr_off == TMR_OFF_RLD_L)) begin
            rld_d = CNT_W'({rld16[15:8], wr_data});
        end else if (wr_en && (wr_off == TMR_OFF_RLD_H)) begin
            rld_d = CNT_W'({wr_data, rld16[7:0]});
        end

        hold_d   = (wr_en && (wr_off == TMR_OFF_CNT_H)) ? (wr_data & HI_MASK) : hold_q;
        shadow_d = rd_snap ? cnt16[15:8] : shadow_q;
    end

    always_comb begin
        rd_byte = 8'hFF;
        case (rd_off)
            TMR_OFF_CTRL:  rd_byte = ctrl_q;
            TMR_OFF_CNT_L: rd_byte = cnt16[7:0];
            TMR_OFF_CNT_H: rd_byte = shadow_q;
            TMR_OFF_RLD_L: rd_byte = rld16[7:0];
            TMR_OFF_RLD_H: rd_byte = rld16[15:8];
`ifdef MCS51_TMR_CAPTURE_EN
            TMR_OFF_CAP_L: rd_byte = cap16[7:0];
            TMR_OFF_CAP_H: rd_byte = cap16[15:8];
`else
            TMR_OFF_CAP_L: rd_byte = 8'hFF;
            TMR_OFF_CAP_H: rd_byte = 8'hFF;
`endif
            TMR_OFF_RSVD:  rd_byte = 8'hFF;
        endcase
    end

    assign run = ctrl_q[TMR_CTRL_RUN];
    assign irq = ctrl_q[TMR_CTRL_OVF] & ctrl_q[TMR_CTRL_IE];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            cnt_q       <= '0;
            rld_q       <= '0;
            shadow_q    <= '0;
            hold_q      <= '0;
            tick_prev_q <= 1'b1;
        end else begin
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            rld_q       <= rld_d;
            shadow_q    <= shadow_d;
            hold_q      <= hold_d;
            tick_prev_q <= tick_prev_d;
        end
    end

endmodule

// File: rtl/mcs51_timer_bank.sv
// Timer/counter bank on the SFR bus: shared prescaler, address decode, read
// mux and NUM_CH channels. Optional capture: define MCS51_TMR_CAPTURE_EN.
module mcs51_timer_bank
    import mcs51_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter int         CNT_W    = 16,
    parameter logic [7:0] SFR_BASE = 8'hC0,
    parameter int         PRESCALE = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        sfr_raddr,
    input  logic              sfr_re,
    output logic [7:0]        sfr_rdata,
    output logic              sfr_hit,
    input  logic [7:0]        sfr_waddr,
    input  logic [7:0]        sfr_wdata,
    input  logic              sfr_we,
    input  logic [NUM_CH-1:0] ext_tick,
    input  logic [NUM_CH-1:0] gate_in,
    input  logic [NUM_CH-1:0] cap_in,
    input  logic              int_ack,
    input  logic [1:0]        ack_ch,
    output logic [NUM_CH-1:0] irq
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      SPAN    = 8'(8 * NUM_CH);

    logic [PS_W-1:0]   pre_q, pre_d;
    logic              pre_tick, any_run;
    logic [NUM_CH-1:0] run_vec;
    logic [7:0]        rdiff, wdiff;
    logic              rhit, whit;
    logic [3:0][7:0]   rd_bytes;

    // Prescaler idles at zero whenever every channel is stopped.
    always_comb begin
        any_run  = |run_vec;
        pre_tick = any_run && (pre_q == PS_LAST);
        if (!any_run || pre_tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    always_comb begin
        rdiff     = sfr_raddr - SFR_BASE;
        wdiff     = sfr_waddr - SFR_BASE;
        rhit      = rdiff < SPAN;
        whit      = wdiff < SPAN;
        sfr_hit   = rhit;
        sfr_rdata = rhit ? rd_bytes[rdiff[4:3]] : 8'hFF;
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            mcs51_tmr_chan #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .pre_tick (pre_tick),
                .ext_tick (ext_tick[i]),
                .gate_in  (gate_in[i]),
                .cap_in   (cap_in[i]),
                .wr_en    (sfr_we && whit && (wdiff[4:3] == 2'(i))),
                .wr_off   (wdiff[2:0]),
                .wr_data  (sfr_wdata),
                .rd_snap  (sfr_re && rhit && (rdiff[4:3] == 2'(i)) && (rdiff[2:0] == TMR_OFF_CNT_L)),
                .rd_off   (rdiff[2:0]),
                .ack      (int_ack && (ack_ch == 2'(i))),
                .rd_byte  (rd_bytes[i]),
                .run      (run_vec[i]),
                .irq      (irq[i])
            );
        end else begin : g_off
            assign rd_bytes[i] = 8'hFF;
        end
    end

endmodule

// File: doc/mcs51_timer_bank.md
Name: mcs51_timer_bank

Overview:
Parametrised timer/counter bank with NUM_CH independent channels of CNT_W bits, memory-mapped into SFR space. Next generation of the fixed Timer0/Timer1 logic in the MCU top level: adds per-channel width, auto-reload at full width, one-shot mode, a shared prescaler, atomic multi-byte access and per-channel interrupt requests. Sits beside the core on the sfr_* bus and drives per-channel irq lines into the interrupt selector.

Parameters:
NUM_CH, 4, number of channels (1..4).
CNT_W, 16, counter/reload width in bits (8..16).
SFR_BASE, 8'hC0, first SFR address; channel i occupies SFR_BASE+8*i .. +7.
PRESCALE, 12, internal-clock divide ratio (1..256).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sfr_raddr  in  8  read address
sfr_re  in  1  read strobe (one cycle per CPU read)
sfr_rdata  out  8  combinational read data
sfr_hit  out  1  sfr_raddr decodes inside this bank
sfr_waddr  in  8  write address
sfr_wdata  in  8  write data
sfr_we  in  1  write strobe
ext_tick  in  NUM_CH  external count inputs, falling-edge counted
gate_in  in  NUM_CH  per-channel gate inputs
cap_in  in  NUM_CH  capture inputs (used only with capture feature)
int_ack  in  1  interrupt acknowledge from core
ack_ch  in  2  channel being acknowledged
irq  out  NUM_CH  irq[i] = CTRL.OVF & CTRL.IE

Behaviour:
- Register offsets per channel: +0 CTRL, +1 CNT_L, +2 CNT_H, +3 RLD_L, +4 RLD_H, +5 CAP_L, +6 CAP_H, +7 reserved (reads 8'hFF). Unmapped address: sfr_rdata=8'hFF, sfr_hit=0.
- CTRL bits: [0] RUN, [2:1] MODE (00 free-run, 01 auto-reload, 10 one-shot, 11 reserved = free-run), [3] CT (1 = count ext_tick falling edges), [4] GATE (count only while gate_in[i]=1), [5] IE, [6] CAPF, [7] OVF.
- Bits at or above CNT_W read 0 and ignore writes. CNT_H/RLD_H/CAP_H read 0 when CNT_W=8.
- Prescaler: free-running counter 0..PRESCALE-1. It emits a one-cycle pre_tick when it wraps. Counts only while any channel has RUN=1, and holds 0 otherwise.
- Count enable: en = RUN & (!GATE | gate_in[i]) & (CT ? fall[i] : pre_tick). fall[i] = prev[i] & ~ext_tick[i]; prev resets to 1.
- On en: if cnt == all-ones(CNT_W), OVF<=1 and:
  - free-run: cnt<=0
  - auto-reload: cnt<=RLD
  - one-shot: cnt<=RLD and RUN<=0
  Otherwise cnt<=cnt+1.
- Atomic read: sfr_re on CNT_L snapshots cnt[CNT_W-1:8] into rd_shadow. CNT_H returns rd_shadow. CNT_L data is the live value.
- Atomic write: CNT_H write loads wr_hold. CNT_L write commits cnt <= {wr_hold, wdata}. RLD_H and RLD_L write directly.
- Interrupt: int_ack with ack_ch=i clears OVF of channel i. ack_ch >= NUM_CH is ignored.
- Same-cycle rules:
  - counter write vs en: write wins, tick is discarded.
  - CPU CTRL write vs overflow: RUN/MODE/CT/GATE/IE take the written value; OVF = written OVF | overflow event.
  - ack vs overflow: OVF ends at 1.
- Reset: all registers, prescaler, shadows and holds = 0; prev = 1; irq = 0. Asynchronous reset mid-count aborts immediately.

Optional Feature:
MCS51_TMR_CAPTURE_EN.
- Defined: a rising edge on cap_in[i] (prev resets to 0) copies cnt into CAP and sets CAPF. CAPF is software-cleared by writing CTRL. A capture and a count in the same cycle capture the pre-increment value.
- Undefined: cap_in is ignored, CAP_L/CAP_H read 8'hFF, and CAPF reads 0.

Decomposition:
- mcs51_pkg gains: tmr_mode_e enum, TMR_CTRL_* bit-index localparams, TMR_OFF_* offset localparams.
- Sub-module mcs51_tmr_chan holds one channel's counter, CTRL, RLD, shadow/hold and capture.
- mcs51_timer_bank holds the prescaler, address decode, read mux and a generate loop over channels.

Test Plan:
- PRESCALE=12, ch0 MODE=00 RUN=1, cnt=16'hFFFE → after 24 clocks cnt=0, OVF=1; with IE=1, irq[0]=1.
- ch1 MODE=01, RLD=16'hFF00, cnt=16'hFFFF, CT=1, single ext_tick falling edge → cnt=16'hFF00, OVF=1, RUN stays 1.
- ch2 MODE=10, RLD=0x0010, cnt=all-ones → after one overflow cnt=0x0010, RUN=0, no further counting over 100 ticks.
- GATE=1 with gate_in low for 36 clocks then high for 36 clocks → exactly 3 increments.
- Read CNT_L at cnt=0x12FF, let it tick to 0x1300, then read CNT_H → returns 0x12. Write CNT_H=0xAB then CNT_L=0xCD → cnt=0xABCD.
- int_ack (ack_ch=0) in the same cycle as a ch0 overflow → OVF remains 1. With MCS51_TMR_CAPTURE_EN defined, a cap_in rising edge at cnt=0x0042 → CAP=0x0042, CAPF=1.
